// File: rtl/output_layer_mac.sv
// output_layer_mac: streams activations against ten per-class weights into ten signed class scores.
// Define OUTPUT_MAC_SATURATE_EN to clamp accumulators instead of wrapping.
module output_layer_mac #(
  parameter int N_IN  = 32,
  parameter int ACT_W = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ACT_W-1:0]        act_in,
  input  logic                    act_valid,
  output logic                    act_ready,
  input  logic [10*W_W-1:0]       weight_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] img_number_0,
  output logic signed [ACC_W-1:0] img_number_1,
  output logic signed [ACC_W-1:0] img_number_2,
  output logic signed [ACC_W-1:0] img_number_3,
  output logic signed [ACC_W-1:0] img_number_4,
  output logic signed [ACC_W-1:0] img_number_5,
  output logic signed [ACC_W-1:0] img_number_6,
  output logic signed [ACC_W-1:0] img_number_7,
  output logic signed [ACC_W-1:0] img_number_8,
  output logic signed [ACC_W-1:0] img_number_9
);
  localparam int CW = $clog2(N_IN);
  localparam int PW = ACT_W + W_W + 1;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic signed [ACC_W-1:0] acc [10];
  logic signed [ACC_W-1:0] acc_nxt [10];
  logic signed [ACC_W-1:0] img [10];
  logic accept, last;
  assign act_ready = state == ACCUM;
  assign busy = state == ACCUM;
  assign accept = act_valid && state == ACCUM;
  assign last = accept && cnt == CW'(N_IN - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (start ? ACCUM : IDLE) : (last ? IDLE : ACCUM);
  for (genvar k = 0; k < 10; k++) begin : g_cls
    logic signed [PW-1:0] prod;
    assign prod = $signed({1'b0, act_in}) * $signed(weight_in[k*W_W +: W_W]);
`ifdef OUTPUT_MAC_SATURATE_EN
    // One guard bit above the wider operand makes the sum exact before clamping.
    localparam int SW = (ACC_W > PW ? ACC_W : PW) + 1;
    localparam logic signed [SW-1:0] SMAX = SW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;
    logic signed [SW-1:0] sum;
    assign sum = $signed(acc[k]) + $signed(prod);
    assign acc_nxt[k] = sum > SMAX ? {1'b0, {(ACC_W-1){1'b1}}} :
                        sum < SMIN ? {1'b1, {(ACC_W-1){1'b0}}} : sum[ACC_W-1:0];
`else
    assign acc_nxt[k] = acc[k] + ACC_W'(prod);
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        acc[i] <= '0;
        img[i] <= '0;
      end
    end else begin
      done <= last;
      if (state == IDLE && start) begin
        cnt <= '0;
        for (int i = 0; i < 10; i++) acc[i] <= '0;
      end else if (accept) begin
        cnt <= last ? '0 : cnt + 1'b1;
        for (int i = 0; i < 10; i++) acc[i] <= acc_nxt[i];
        if (last)
          for (int i = 0; i < 10; i++) img[i] <= acc_nxt[i];
      end
    end
  assign img_number_0 = img[0];
  assign img_number_1 = img[1];
  assign img_number_2 = img[2];
  assign img_number_3 = img[3];
  assign img_number_4 = img[4];
  assign img_number_5 = img[5];
  assign img_number_6 = img[6];
  assign img_number_7 = img[7];
  assign img_number_8 = img[8];
  assign img_number_9 = img[9];
endmodule

// File: tb/tb_output_layer_mac.sv
// tb_output_layer_mac: scoreboard bench driving a 26-bit and a 16-bit accumulator build with shared stimulus.
module tb_output_layer_mac;
  localparam int N = 4;
  logic clk = 0, rst = 0, start = 0, act_valid = 0;
  logic [7:0] act_in = 0;
  logic [79:0] weight_in = 0;
  logic act_ready, busy, done, act_ready16, busy16, done16;
  logic signed [25:0] s26 [10];
  logic signed [15:0] s16 [10];
  int vectors = 0, errors = 0;
  longint exp_q [$];
  longint pub26 [10], pub16 [10];
  int act_a [N];
  int w_a [N][10];

  always #5 clk = ~clk;

  output_layer_mac #(.N_IN(N), .ACT_W(8), .W_W(8), .ACC_W(26)) dut (
    .clk(clk), .rst(rst), .start(start), .act_in(act_in), .act_valid(act_valid),
    .act_ready(act_ready), .weight_in(weight_in), .busy(busy), .done(done),
    .img_number_0(s26[0]), .img_number_1(s26[1]), .img_number_2(s26[2]), .img_number_3(s26[3]),
    .img_number_4(s26[4]), .img_number_5(s26[5]), .img_number_6(s26[6]), .img_number_7(s26[7]),
    .img_number_8(s26[8]), .img_number_9(s26[9]));

  output_layer_mac #(.N_IN(N), .ACT_W(8), .W_W(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .act_in(act_in), .act_valid(act_valid),
    .act_ready(act_ready16), .weight_in(weight_in), .busy(busy16), .done(done16),
    .img_number_0(s16[0]), .img_number_1(s16[1]), .img_number_2(s16[2]), .img_number_3(s16[3]),
    .img_number_4(s16[4]), .img_number_5(s16[5]), .img_number_6(s16[6]), .img_number_7(s16[7]),
    .img_number_8(s16[8]), .img_number_9(s16[9]));

  task automatic chk(input string name, input longint got, input longint want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference: exact integer sum, then either clamped or reduced modulo 2^bits.
  function automatic longint step(input longint acc, input longint p, input int bits);
    longint one = 1;
    longint mx = (one << (bits - 1)) - 1;
    longint s = acc + p;
`ifdef OUTPUT_MAC_SATURATE_EN
    return s > mx ? mx : s < -mx - 1 ? -mx - 1 : s;
`else
    s = s & ((one << bits) - 1);
    return s > mx ? s - (one << bits) : s;
`endif
  endfunction

  task automatic push_expect();
    longint e26 [10], e16 [10];
    for (int k = 0; k < 10; k++) begin
      e26[k] = 0;
      e16[k] = 0;
      for (int i = 0; i < N; i++) begin
        e26[k] = step(e26[k], longint'(act_a[i]) * longint'(w_a[i][k]), 26);
        e16[k] = step(e16[k], longint'(act_a[i]) * longint'(w_a[i][k]), 16);
      end
    end
    for (int k = 0; k < 10; k++) exp_q.push_back(e26[k]);
    for (int k = 0; k < 10; k++) exp_q.push_back(e16[k]);
  endtask

  task automatic drive_beat(input int i);
    act_valid = 1;
    act_in = 8'(act_a[i]);
    for (int k = 0; k < 10; k++) weight_in[k*8 +: 8] = 8'(w_a[i][k]);
  endtask

  // Entered and left #1 after a rising edge; chained asserts start in the done cycle.
  task automatic run_image(input bit stall, input bit poke, input bit chained);
    push_expect();
    if (!chained) begin
      @(posedge clk); #1;
    end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("ready_after_start", act_ready, 1);
    chk("busy_in_accum", busy, 1);
    for (int i = 0; i < N; i++) begin
      if (stall) begin
        act_valid = 0;
        act_in = 8'($urandom);
        start = poke;
        @(posedge clk); #1;
      end
      drive_beat(i);
      start = poke;
      @(posedge clk); #1;
    end
    act_valid = 0;
    start = 0;
    chk("done_after_last", done, 1);
    chk("ready_in_idle", act_ready, 0);
    chk("busy_in_idle", busy, 0);
  endtask

  task automatic set_uniform(input int a, input int w);
    for (int i = 0; i < N; i++) begin
      act_a[i] = a;
      for (int k = 0; k < 10; k++) w_a[i][k] = w;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++) begin
      act_a[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      for (int k = 0; k < 10; k++) w_a[i][k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (done) begin
        chk("done_both_builds", done16, 1);
        if (exp_q.size() < 20) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending image");
        end else begin
          for (int k = 0; k < 10; k++) pub26[k] = exp_q.pop_front();
          for (int k = 0; k < 10; k++) pub16[k] = exp_q.pop_front();
          for (int k = 0; k < 10; k++) begin
            chk($sformatf("score26_%0d", k), s26[k], pub26[k]);
            chk($sformatf("score16_%0d", k), s16[k], pub16[k]);
          end
        end
      end else
        for (int k = 0; k < 10; k++) begin
          chk($sformatf("held26_%0d", k), s26[k], pub26[k]);
          chk($sformatf("held16_%0d", k), s16[k], pub16[k]);
        end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    errors++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 10; k++) begin
      pub26[k] = 0;
      pub16[k] = 0;
    end
    #1 rst = 1;
    #1;
    chk("rst_ready", act_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    for (int k = 0; k < 10; k++) chk($sformatf("rst_score_%0d", k), s26[k], 0);
    @(posedge clk); #1 rst = 0;

    set_uniform(0, 1);
    for (int i = 0; i < N; i++) begin
      act_a[i] = i + 1;
      w_a[i][3] = 10;
    end
    run_image(0, 0, 0);
    chk("basic_c3", s26[3], 100);
    chk("basic_c0", s26[0], 10);
    run_image(1, 0, 0);
    chk("stall_c3", s26[3], 100);
    chk("stall_c9", s26[9], 10);

    // Abort after two accepted beats.
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    drive_beat(0);
    @(posedge clk); #1 drive_beat(1);
    @(posedge clk); #1 act_valid = 0;
    #2 rst = 1;
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      pub26[k] = 0;
      pub16[k] = 0;
    end
    #1;
    chk("abort_ready", act_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int k = 0; k < 10; k++) chk($sformatf("abort_score_%0d", k), s26[k], 0);
    @(posedge clk); #1 rst = 0;
    run_image(0, 0, 0);
    chk("after_abort_c3", s26[3], 100);

    set_random();
    for (int i = 0; i < N; i++) begin
      act_a[i] = 255;
      w_a[i][0] = -128;
    end
    run_image(0, 0, 0);
    chk("neg_c0", s26[0], -130560);

    set_uniform(255, 127);
    run_image(0, 0, 0);
`ifdef OUTPUT_MAC_SATURATE_EN
    chk("ovf16_c0", s16[0], 32767);
`else
    chk("ovf16_c0", s16[0], -1532);
`endif

    set_random();
    run_image(0, 1, 0);
    set_random();
    run_image(1, 1, 0);
    set_random();
    run_image(0, 0, 1);

    repeat (40) begin
      set_random();
      run_image(1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
